// File: rtl/spi_mem_loader_pkg.sv
// Shared constants and types for the SPI instruction-memory loader.
// Holds the FSM state encoding, default geometry and the instruction-word
// field layout also used by the memory and finiteStateMachine.
package spi_mem_loader_pkg;

  localparam int unsigned ADDR_W_DEF      = 16;
  localparam int unsigned DATA_W_DEF      = 10;
  localparam int unsigned MEM_DEPTH_DEF   = 1024;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // Instruction word layout: 8 data bits, control bits above them
  localparam int unsigned INSTR_DATA_LSB = 0;
  localparam int unsigned INSTR_DATA_MSB = 7;
  localparam int unsigned INSTR_CTRL_LSB = 8;
  localparam int unsigned INSTR_CTRL_MSB = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } loaderState_t;

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_mem_loader_if.sv
// Host pins plus memory write port and frame status of the loader.
// master: host/system side (drives ext_*, observes memory port and status)
// slave : the loader (samples ext_*, drives memory port and status)
interface spi_mem_loader_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 10
);
  logic              ext_sclk;
  logic              ext_mosi;
  logic              ext_cs_n;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              load_active;
  logic              frame_done;
  logic              frame_err;
  logic [ADDR_W-1:0] word_count;

  modport master (
    output ext_sclk, ext_mosi, ext_cs_n,
    input  mem_we, mem_addr, mem_data, load_active, frame_done, frame_err, word_count
  );

  modport slave (
    input  ext_sclk, ext_mosi, ext_cs_n,
    output mem_we, mem_addr, mem_data, load_active, frame_done, frame_err, word_count
  );
endinterface

// File: rtl/spi_mem_loader_input_sync.sv
// Synchronizer for the asynchronous host pins plus sclk rising-edge detect.
// Ports: clk, rst_n; ext_sclk/ext_mosi/ext_cs_n raw pins in;
// sclk_rise (one clk per host rising edge), mosi_s, cs_n_s synced out.
module spi_input_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ext_sclk,
  input  logic ext_mosi,
  input  logic ext_cs_n,
  output logic sclk_rise,
  output logic mosi_s,
  output logic cs_n_s
);

  logic [SYNC_STAGES-1:0] sclkSync;
  logic [SYNC_STAGES-1:0] mosiSync;
  logic [SYNC_STAGES-1:0] csSync;

  // cs_n chain resets deasserted so reset release never looks like a frame start.
  // sclk_rise is the extra edge flop: it sees the value entering the last stage
  // against the last stage itself, so it is aligned with the synced sclk going high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclkSync  <= '0;
      mosiSync  <= '0;
      csSync    <= '1;
      sclk_rise <= 1'b0;
    end else begin
      sclkSync  <= {sclkSync[SYNC_STAGES-2:0], ext_sclk};
      mosiSync  <= {mosiSync[SYNC_STAGES-2:0], ext_mosi};
      csSync    <= {csSync[SYNC_STAGES-2:0], ext_cs_n};
      sclk_rise <= sclkSync[SYNC_STAGES-2] & ~sclkSync[SYNC_STAGES-1];
    end
  end

  assign mosi_s = mosiSync[SYNC_STAGES-1];
  assign cs_n_s = csSync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mem_loader.sv
// SPI-slave frame receiver that loads the display instruction memory.
// Frame: cs_n low, ADDR_W address bits, then DATA_W-bit words MSB first,
// written to consecutive addresses; cs_n high closes the frame.
// Ports: clk, rst_n (async active-low); bus (slave modport) carrying the
// host pins, the memory write port and load_active/frame_done/frame_err/word_count.
module spi_mem_loader
  import spi_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic             clk,
  input logic             rst_n,
  spi_mem_loader_if.slave bus
);

  localparam int unsigned     SH_W      = maxOf(ADDR_W, DATA_W);
  localparam int unsigned     CNT_W     = $clog2(SH_W + 1);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

  logic sclkRise, mosiS, csNS;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
    .clk      (clk),
    .rst_n    (rst_n),
    .ext_sclk (bus.ext_sclk),
    .ext_mosi (bus.ext_mosi),
    .ext_cs_n (bus.ext_cs_n),
    .sclk_rise(sclkRise),
    .mosi_s   (mosiS),
    .cs_n_s   (csNS)
  );

  loaderState_t      stateQ, stateNext;
  logic [SH_W-1:0]   shiftQ, shiftNext, shifted;
  logic [CNT_W-1:0]  bitCntQ, bitCntNext;
  logic              memWeQ, memWeNext;
  logic [ADDR_W-1:0] memAddrQ, memAddrNext;
  logic [DATA_W-1:0] memDataQ, memDataNext;
  logic              loadActiveQ, loadActiveNext;
  logic              frameDoneQ, frameDoneNext;
  logic              frameErrQ, frameErrNext;
  logic [ADDR_W-1:0] wordCntQ, wordCntNext;
  logic              wrPendQ, wrPendNext;   // word assembled, write slot next
  logic              incPendQ, incPendNext; // write slot done, advance address next
  logic              csPrevQ;
  logic              csFall, inRange;

  assign csFall  = csPrevQ & ~csNS;
  assign inRange = {1'b0, memAddrQ} < DEPTH_LIM;
  assign shifted = {shiftQ[SH_W-2:0], mosiS};

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ      <= ST_IDLE;
      shiftQ      <= '0;
      bitCntQ     <= '0;
      memWeQ      <= 1'b0;
      memAddrQ    <= '0;
      memDataQ    <= '0;
      loadActiveQ <= 1'b0;
      frameDoneQ  <= 1'b0;
      frameErrQ   <= 1'b0;
      wordCntQ    <= '0;
      wrPendQ     <= 1'b0;
      incPendQ    <= 1'b0;
      csPrevQ     <= 1'b1;
    end else begin
      stateQ      <= stateNext;
      shiftQ      <= shiftNext;
      bitCntQ     <= bitCntNext;
      memWeQ      <= memWeNext;
      memAddrQ    <= memAddrNext;
      memDataQ    <= memDataNext;
      loadActiveQ <= loadActiveNext;
      frameDoneQ  <= frameDoneNext;
      frameErrQ   <= frameErrNext;
      wordCntQ    <= wordCntNext;
      wrPendQ     <= wrPendNext;
      incPendQ    <= incPendNext;
      csPrevQ     <= csNS;
    end
  end

  // Next-state and output logic
  always_comb begin
    stateNext      = stateQ;
    shiftNext      = shiftQ;
    bitCntNext     = bitCntQ;
    memWeNext      = 1'b0;
    memAddrNext    = memAddrQ;
    memDataNext    = memDataQ;
    loadActiveNext = loadActiveQ;
    frameDoneNext  = 1'b0;
    frameErrNext   = frameErrQ;
    wordCntNext    = wordCntQ;
    wrPendNext     = 1'b0;
    incPendNext    = 1'b0;

    // Write slot: out-of-range addresses raise the error instead of writing
    if (wrPendQ) begin
      if (inRange) memWeNext    = 1'b1;
      else         frameErrNext = 1'b1;
      incPendNext = 1'b1;
    end

    // Address always advances (wrapping); count only real writes
    if (incPendQ) begin
      memAddrNext = memAddrQ + ADDR_W'(1);
      if (memWeQ) wordCntNext = wordCntQ + ADDR_W'(1);
    end

    unique case (stateQ)
      ST_IDLE: begin
        if (csFall) begin
          stateNext      = ST_ADDR;
          shiftNext      = '0;
          bitCntNext     = '0;
          wordCntNext    = '0;
          frameErrNext   = 1'b0;
          loadActiveNext = 1'b1;
        end
      end

      ST_ADDR: begin
        if (csNS) begin
          stateNext      = ST_IDLE;
          loadActiveNext = 1'b0;
          frameErrNext   = 1'b1;
        end else if (sclkRise) begin
          shiftNext = shifted;
          if (bitCntQ == CNT_W'(ADDR_W - 1)) begin
            memAddrNext = shifted[ADDR_W-1:0];
            bitCntNext  = '0;
            stateNext   = ST_DATA;
          end else begin
            bitCntNext = bitCntQ + CNT_W'(1);
          end
        end
      end

      ST_DATA: begin
        // A completing word wins over a coincident cs_n rise; the close then
        // waits until the write and address advance have drained.
        if (sclkRise && bitCntQ == CNT_W'(DATA_W - 1)) begin
          shiftNext   = shifted;
          memDataNext = shifted[DATA_W-1:0];
          bitCntNext  = '0;
          wrPendNext  = 1'b1;
        end else if (csNS && !wrPendQ && !incPendQ) begin
          stateNext      = ST_IDLE;
          loadActiveNext = 1'b0;
          if (bitCntQ == '0) frameDoneNext = 1'b1;
          else               frameErrNext  = 1'b1;
        end else if (sclkRise) begin
          shiftNext  = shifted;
          bitCntNext = bitCntQ + CNT_W'(1);
        end
      end

      default: stateNext = ST_IDLE;
    endcase
  end

  assign bus.mem_we      = memWeQ;
  assign bus.mem_addr    = memAddrQ;
  assign bus.mem_data    = memDataQ;
  assign bus.load_active = loadActiveQ;
  assign bus.frame_done  = frameDoneQ;
  assign bus.frame_err   = frameErrQ;
  assign bus.word_count  = wordCntQ;

endmodule

// File: tb/tb_spi_mem_loader.sv
// Bench for spi_mem_loader: directed and randomized host frames checked
// against a frame-level model of the expected writes and status.
module tb_spi_mem_loader;
  import spi_mem_loader_pkg::*;

  localparam int unsigned S     = SYNC_STAGES_DEF;
  localparam int unsigned DEPTH = MEM_DEPTH_DEF;
  localparam int unsigned HALF  = S + 2;

  typedef struct {
    logic [15:0] a;
    logic [9:0]  d;
    int unsigned cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mem_loader_if #(.ADDR_W(16), .DATA_W(10)) busIf ();

  spi_mem_loader dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busIf)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned riseCyc = 0;
  int unsigned doneCnt = 0;
  wr_t gotQ[$];
  wr_t expQ[$];
  logic [9:0] fw [0:3];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the memory port and done pulses away from the active edge
  always @(negedge clk) begin
    if (busIf.mem_we) gotQ.push_back('{a: busIf.mem_addr, d: busIf.mem_data, cyc: cyc});
    if (busIf.frame_done) doneCnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitClk(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b, input bit raiseCs);
    busIf.ext_mosi = b;
    waitClk(HALF);
    busIf.ext_sclk = 1'b1;
    if (raiseCs) busIf.ext_cs_n = 1'b1;
    riseCyc = cyc;
    waitClk(HALF);
    busIf.ext_sclk = 1'b0;
  endtask

  // One host frame plus the frame-level expectations derived from it
  task automatic runFrame(input logic [15:0] addr, input int addrBits, input int nWords,
                          input int partial, input bit coinc);
    bit expErr, expDone;
    int unsigned expCnt;
    logic [15:0] a;
    expQ.delete();
    gotQ.delete();
    doneCnt = 0;
    expErr  = 1'b0;
    expDone = 1'b0;
    expCnt  = 0;

    busIf.ext_cs_n = 1'b0;
    waitClk(HALF);
    check("load_active_start", 32'(busIf.load_active), 32'd1);
    check("frame_err_cleared", 32'(busIf.frame_err), 32'd0);

    for (int i = 0; i < addrBits; i++) sendBit(addr[15-i], 1'b0);
    if (addrBits < 16) begin
      expErr = 1'b1;
    end else begin
      for (int j = 0; j < nWords; j++) begin
        for (int b = 0; b < 10; b++)
          sendBit(fw[j][9-b], coinc && partial == 0 && j == nWords - 1 && b == 9);
        a = 16'(addr + 16'(j));
        if (32'(a) < DEPTH) begin
          expQ.push_back('{a: a, d: fw[j], cyc: riseCyc + S + 2});
          expCnt++;
        end else begin
          expErr = 1'b1;
        end
      end
      for (int p = 0; p < partial; p++) sendBit(1'($urandom), 1'b0);
      if (partial > 0) expErr = 1'b1;
      else             expDone = 1'b1;
    end

    if (!(coinc && partial == 0 && nWords > 0 && addrBits == 16)) begin
      waitClk(HALF);
      busIf.ext_cs_n = 1'b1;
    end
    waitClk(12);

    check("n_writes", 32'(gotQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      check("wr_addr", 32'(gotQ[i].a), 32'(expQ[i].a));
      check("wr_data", 32'(gotQ[i].d), 32'(expQ[i].d));
      check("wr_latency", gotQ[i].cyc, expQ[i].cyc);
    end
    check("frame_done_pulses", doneCnt, 32'(expDone));
    check("frame_err", 32'(busIf.frame_err), 32'(expErr));
    check("word_count", 32'(busIf.word_count), expCnt);
    check("load_active_end", 32'(busIf.load_active), 32'd0);
  endtask

  initial begin
    int addrBits, nWords, partial, r;
    logic [15:0] addr;
    bit coinc;
    logic [15:0] rstAddr;
    logic [9:0] rstWord;

    busIf.ext_sclk = 1'b0;
    busIf.ext_mosi = 1'b0;
    busIf.ext_cs_n = 1'b1;
    waitClk(3);
    rst_n = 1'b1;
    waitClk(3);

    check("rst_mem_we", 32'(busIf.mem_we), 32'd0);
    check("rst_mem_addr", 32'(busIf.mem_addr), 32'd0);
    check("rst_mem_data", 32'(busIf.mem_data), 32'd0);
    check("rst_load_active", 32'(busIf.load_active), 32'd0);
    check("rst_frame_done", 32'(busIf.frame_done), 32'd0);
    check("rst_frame_err", 32'(busIf.frame_err), 32'd0);
    check("rst_word_count", 32'(busIf.word_count), 32'd0);

    // Basic two-word frame
    fw[0] = 10'h3A5; fw[1] = 10'h0FF;
    runFrame(16'h0005, 16, 2, 0, 1'b0);
    // Close after address plus 4 data bits
    runFrame(16'h0123, 16, 0, 4, 1'b0);
    // Last in-range word then an out-of-range one
    fw[0] = 10'h155; fw[1] = 10'h2AA;
    runFrame(16'h03FF, 16, 2, 0, 1'b0);
    // Clean frame right after an error frame
    fw[0] = 10'h001;
    runFrame(16'h0010, 16, 1, 0, 1'b0);
    // Address wrap: 0xFFFF is out of range, 0x0000 is written
    fw[0] = 10'h11F; fw[1] = 10'h3C3;
    runFrame(16'hFFFF, 16, 2, 0, 1'b0);
    // Final data bit coincident with cs_n rise
    fw[0] = 10'h0F0; fw[1] = 10'h30F;
    runFrame(16'h0020, 16, 2, 0, 1'b1);
    // Close inside the address phase
    runFrame(16'h0007, 9, 0, 0, 1'b0);

    // Reset after one word and 7 bits of the next
    rstAddr = 16'h0040;
    rstWord = 10'h2C3;
    gotQ.delete();
    busIf.ext_cs_n = 1'b0;
    waitClk(HALF);
    for (int i = 0; i < 16; i++) sendBit(rstAddr[15-i], 1'b0);
    for (int b = 0; b < 10; b++) sendBit(rstWord[9-b], 1'b0);
    for (int b = 0; b < 7; b++) sendBit(1'b1, 1'b0);
    waitClk(2);
    check("pre_rst_writes", 32'(gotQ.size()), 32'd1);
    check("pre_rst_word_count", 32'(busIf.word_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mem_we", 32'(busIf.mem_we), 32'd0);
    check("async_rst_mem_addr", 32'(busIf.mem_addr), 32'd0);
    check("async_rst_mem_data", 32'(busIf.mem_data), 32'd0);
    check("async_rst_load_active", 32'(busIf.load_active), 32'd0);
    check("async_rst_frame_err", 32'(busIf.frame_err), 32'd0);
    check("async_rst_word_count", 32'(busIf.word_count), 32'd0);
    busIf.ext_cs_n = 1'b1;
    busIf.ext_sclk = 1'b0;
    waitClk(3);
    gotQ.delete();
    rst_n = 1'b1;
    waitClk(20);
    check("post_rst_writes", 32'(gotQ.size()), 32'd0);
    check("post_rst_load_active", 32'(busIf.load_active), 32'd0);
    check("post_rst_frame_done", 32'(busIf.frame_done), 32'd0);

    // Frame after reset proves the FSM is back in IDLE
    fw[0] = 10'h2B7;
    runFrame(16'h0100, 16, 1, 0, 1'b0);

    // Randomized frames
    for (int f = 0; f < 10; f++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0)      addr = 16'($urandom);
      else if (r == 1) addr = 16'(1020 + $urandom_range(0, 6));
      else             addr = 16'($urandom_range(0, 1023));
      nWords   = int'($urandom_range(0, 3));
      partial  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
      addrBits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 16;
      coinc    = (partial == 0 && nWords > 0 && $urandom_range(0, 1) == 1);
      for (int j = 0; j < 4; j++) fw[j] = 10'($urandom);
      runFrame(addr, addrBits, nWords, partial, coinc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
